// File: rtl/tone_decoder.sv
// tone_decoder: measures the period of a piano square-wave tone on beep_in
// (in clk_5MHz cycles) and decodes it into one of four keys (Hdo/Hre/Hmi/Hfa).
// A key is only reported after two consecutive periods classify the same,
// and a long silence drops the decoder back to IDLE with the key cleared.
// state_dbg exposes the FSM state (0 IDLE, 1 ARMED, 2 TRACK) for checkers.
module tone_decoder (
    input  logic        clk_5MHz,
    input  logic        rst,
    input  logic        beep_in,
    output logic [3:0]  key_out,
    output logic        key_valid,
    output logic        key_change,
    output logic [15:0] period_out,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,  // no reference edge yet
        ARMED = 2'd1,  // one rising edge seen, first period being counted
        TRACK = 2'd2   // at least one full period measured
    } state_t;

    // Nominal periods are 2*(16384-origin) for origins 6826/7871/8798/9224.
    localparam logic [15:0] NOM_HDO     = 16'd19116;
    localparam logic [15:0] NOM_HRE     = 16'd17026;
    localparam logic [15:0] NOM_HMI     = 16'd15172;
    localparam logic [15:0] NOM_HFA     = 16'd14320;
    localparam logic [15:0] TOL         = 16'd64;
    localparam logic [15:0] TIMEOUT_CNT = 16'd32767;
    localparam logic [15:0] CNT_MAX     = 16'hFFFF;

    localparam logic [3:0]  KEY_NONE = 4'b0000;
    localparam logic [3:0]  KEY_HDO  = 4'b0001;
    localparam logic [3:0]  KEY_HRE  = 4'b0010;
    localparam logic [3:0]  KEY_HMI  = 4'b0100;
    localparam logic [3:0]  KEY_HFA  = 4'b1000;

    // Inclusive window test: nom-TOL <= p <= nom+TOL.
    function automatic logic in_window(input logic [15:0] p, input logic [15:0] nom);
        return (p >= (nom - TOL)) && (p <= (nom + TOL));
    endfunction

    // Map a measured period to a one-hot key; anything outside every window is silence/unknown.
    function automatic logic [3:0] classify(input logic [15:0] p);
        logic [3:0] k;
        k = KEY_NONE;
        if (in_window(p, NOM_HDO)) begin
            k = KEY_HDO;
        end else if (in_window(p, NOM_HRE)) begin
            k = KEY_HRE;
        end else if (in_window(p, NOM_HMI)) begin
            k = KEY_HMI;
        end else if (in_window(p, NOM_HFA)) begin
            k = KEY_HFA;
        end
        return k;
    endfunction

    logic       sync_ff1;
    logic       sync_ff2;
    logic       edge_reg;
    logic       rise;

    state_t     state;
    state_t     state_next;

    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic [15:0] period_next;
    logic [3:0]  cand;
    logic [3:0]  cand_next;
    logic [1:0]  hits;
    logic [1:0]  hits_next;
    logic [3:0]  key_next;
    logic        key_change_next;

    logic [15:0] meas_p;
    logic [3:0]  code;
    logic [3:0]  cand_q;
    logic [1:0]  hits_q;
    logic        load_key;

    // Two-flop synchronizer for the asynchronous tone, followed by the edge register.
    always_ff @(posedge clk_5MHz) begin
        if (rst) begin
            sync_ff1 <= 1'b0;
            sync_ff2 <= 1'b0;
            edge_reg <= 1'b0;
        end else begin
            sync_ff1 <= beep_in;
            sync_ff2 <= sync_ff1;
            edge_reg <= sync_ff2;
        end
    end

    assign rise = sync_ff2 & ~edge_reg;

    // Period of the interval closed by this rise, plus its classification and qualification update.
    always_comb begin
        meas_p   = (cnt == CNT_MAX) ? CNT_MAX : (cnt + 16'd1);
        code     = classify(meas_p);
        cand_q   = cand;
        hits_q   = hits;
        if (code == cand) begin
            hits_q = (hits == 2'd2) ? 2'd2 : (hits + 2'd1);
        end else begin
            cand_q = code;
            hits_q = 2'd1;
        end
        // Two matching periods in a row are required before the key may move.
        load_key = (hits_q == 2'd2) && (code != key_out);
    end

    // FSM state register.
    always_ff @(posedge clk_5MHz) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath next values; a rise always beats a coincident timeout.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        period_next     = period_out;
        cand_next       = cand;
        hits_next       = hits;
        key_next        = key_out;
        key_change_next = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = 16'd0;
                if (rise) begin
                    state_next = ARMED;
                end
            end
            ARMED, TRACK: begin
                if (rise) begin
                    state_next  = TRACK;
                    cnt_next    = 16'd0;
                    period_next = meas_p;
                    cand_next   = cand_q;
                    hits_next   = hits_q;
                    if (load_key) begin
                        key_next        = code;
                        key_change_next = 1'b1;
                    end
                end else if (cnt == TIMEOUT_CNT) begin
                    // Silence: forget the tone but keep the last measured period visible.
                    state_next      = IDLE;
                    cnt_next        = 16'd0;
                    cand_next       = KEY_NONE;
                    hits_next       = 2'd0;
                    key_next        = KEY_NONE;
                    key_change_next = (key_out != KEY_NONE);
                end else begin
                    cnt_next = (cnt == CNT_MAX) ? CNT_MAX : (cnt + 16'd1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 16'd0;
            end
        endcase
    end

    // Datapath registers: counter, qualification, key and period outputs.
    always_ff @(posedge clk_5MHz) begin
        if (rst) begin
            cnt        <= 16'd0;
            period_out <= 16'd0;
            cand       <= KEY_NONE;
            hits       <= 2'd0;
            key_out    <= KEY_NONE;
            key_change <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            period_out <= period_next;
            cand       <= cand_next;
            hits       <= hits_next;
            key_out    <= key_next;
            key_change <= key_change_next;
        end
    end

    assign key_valid = (key_out != KEY_NONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder: drives a square-wave tone as a sequence of rising edges.
// Each table row is one rising edge of beep_in; n is the spacing in clock
// cycles to the next rising edge, and the expected values are what the
// decoder shows a few cycles after the rise at the start of that row.
module tb_tone_decoder;

    localparam int ACT_NONE    = 0;
    localparam int ACT_RESET   = 1;  // assert rst mid-period after beep goes low
    localparam int ACT_TIMEOUT = 2;  // hold beep low for 40000 cycles
    localparam int NROWS       = 17;

    typedef struct {
        int          n;
        logic [15:0] exp_period;
        logic [3:0]  exp_key;
        logic [1:0]  exp_state;
        int          exp_pulses;
        int          action;
    } row_t;

    logic        clk_5MHz = 1'b0;
    logic        rst;
    logic        beep_in;
    logic [3:0]  key_out;
    logic        key_valid;
    logic        key_change;
    logic [15:0] period_out;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    logic prev_kc = 1'b0;
    row_t rows[NROWS];

    tone_decoder dut (
        .clk_5MHz  (clk_5MHz),
        .rst       (rst),
        .beep_in   (beep_in),
        .key_out   (key_out),
        .key_valid (key_valid),
        .key_change(key_change),
        .period_out(period_out),
        .state_dbg (state_dbg)
    );

    // 5 MHz clock
    always #100 clk_5MHz = ~clk_5MHz;

    task automatic check(input string name, input int row, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s row %0d: got %0d expected %0d", name, row, got, exp);
        end
    endtask

    // key_change must never be high on two consecutive cycles.
    always @(negedge clk_5MHz) begin
        if (key_change === 1'b1) begin
            check("key_change_back_to_back", -1, {31'd0, prev_kc}, 32'd0);
        end
        prev_kc = key_change;
    end

    task automatic check_row_outputs(input int r, input int pulses);
        check("period_out", r, {16'd0, period_out}, {16'd0, rows[r].exp_period});
        check("key_out", r, {28'd0, key_out}, {28'd0, rows[r].exp_key});
        check("key_valid", r, {31'd0, key_valid}, {31'd0, (rows[r].exp_key != 4'b0000)});
        check("state", r, {30'd0, state_dbg}, {30'd0, rows[r].exp_state});
        check("key_change_pulses", r, pulses, rows[r].exp_pulses);
    endtask

    // Reset in the middle of a measurement while a key is being reported.
    task automatic mid_reset(input int r);
        for (int i = 7; i <= rows[r].n / 2 + 100; i++) begin
            @(negedge clk_5MHz);
            if (i == rows[r].n / 2) beep_in = 1'b0;
        end
        check("pre_reset_key", r, {28'd0, key_out}, 32'd1);
        rst = 1'b1;
        @(negedge clk_5MHz);
        check("reset_key_out", r, {28'd0, key_out}, 32'd0);
        check("reset_key_valid", r, {31'd0, key_valid}, 32'd0);
        check("reset_key_change", r, {31'd0, key_change}, 32'd0);
        check("reset_period_out", r, {16'd0, period_out}, 32'd0);
        check("reset_state", r, {30'd0, state_dbg}, 32'd0);
        rst = 1'b0;
        repeat (50) @(negedge clk_5MHz);
        check("post_reset_state", r, {30'd0, state_dbg}, 32'd0);
        check("post_reset_key", r, {28'd0, key_out}, 32'd0);
    endtask

    // Silence after the rise: timeout on the edge after cnt reaches 32767.
    task automatic silence_timeout(input int r);
        beep_in = 1'b0;
        repeat (32764) @(negedge clk_5MHz);
        check("pre_timeout_state", r, {30'd0, state_dbg}, 32'd2);
        check("pre_timeout_key", r, {28'd0, key_out}, 32'd8);
        check("pre_timeout_change", r, {31'd0, key_change}, 32'd0);
        @(negedge clk_5MHz);
        check("timeout_state", r, {30'd0, state_dbg}, 32'd0);
        check("timeout_key_out", r, {28'd0, key_out}, 32'd0);
        check("timeout_key_valid", r, {31'd0, key_valid}, 32'd0);
        check("timeout_key_change", r, {31'd0, key_change}, 32'd1);
        check("timeout_period_held", r, {16'd0, period_out}, 32'd15172);
        repeat (40000 - 32765) @(negedge clk_5MHz);
        check("idle_after_timeout_state", r, {30'd0, state_dbg}, 32'd0);
        check("idle_after_timeout_change", r, {31'd0, key_change}, 32'd0);
    endtask

    initial begin
        //           n      period        key      state  pulses action
        rows[0]  = '{19100, 16'd0,     4'b0000, 2'd1, 0, ACT_NONE};    // arm from reset
        rows[1]  = '{19130, 16'd19100, 4'b0000, 2'd2, 0, ACT_NONE};    // Hdo candidate
        rows[2]  = '{19100, 16'd19130, 4'b0001, 2'd2, 1, ACT_NONE};    // jittered Hdo qualifies
        rows[3]  = '{19130, 16'd19100, 4'b0001, 2'd2, 0, ACT_RESET};   // stable, then reset
        rows[4]  = '{19116, 16'd0,     4'b0000, 2'd1, 0, ACT_NONE};    // re-arm after reset
        rows[5]  = '{19116, 16'd19116, 4'b0000, 2'd2, 0, ACT_NONE};    // period after 2nd rise
        rows[6]  = '{17026, 16'd19116, 4'b0001, 2'd2, 1, ACT_NONE};    // Hdo at 3rd rise
        rows[7]  = '{17026, 16'd17026, 4'b0001, 2'd2, 0, ACT_NONE};    // Hre candidate
        rows[8]  = '{14320, 16'd17026, 4'b0010, 2'd2, 1, ACT_NONE};    // Hre
        rows[9]  = '{14320, 16'd14320, 4'b0010, 2'd2, 0, ACT_NONE};    // one Hfa period: holds Hre
        rows[10] = '{15172, 16'd14320, 4'b1000, 2'd2, 1, ACT_NONE};    // Hfa
        rows[11] = '{0,     16'd15172, 4'b1000, 2'd2, 0, ACT_TIMEOUT}; // one Hmi period, silence
        rows[12] = '{15236, 16'd15172, 4'b0000, 2'd1, 0, ACT_NONE};    // arm, period held
        rows[13] = '{15236, 16'd15236, 4'b0000, 2'd2, 0, ACT_NONE};    // upper Hmi edge candidate
        rows[14] = '{15237, 16'd15236, 4'b0100, 2'd2, 1, ACT_NONE};    // Hmi at window edge
        rows[15] = '{15237, 16'd15237, 4'b0100, 2'd2, 0, ACT_NONE};    // just outside: one period
        rows[16] = '{50,    16'd15237, 4'b0000, 2'd2, 1, ACT_NONE};    // second outside -> 0000

        rst     = 1'b1;
        beep_in = 1'b0;
        repeat (3) @(negedge clk_5MHz);
        check("init_period_out", -1, {16'd0, period_out}, 32'd0);
        check("init_key_out", -1, {28'd0, key_out}, 32'd0);
        check("init_key_valid", -1, {31'd0, key_valid}, 32'd0);
        check("init_key_change", -1, {31'd0, key_change}, 32'd0);
        check("init_state", -1, {30'd0, state_dbg}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk_5MHz);

        for (int r = 0; r < NROWS; r++) begin
            int pulses;
            pulses  = 0;
            beep_in = 1'b1;
            for (int i = 1; i <= 6; i++) begin
                @(negedge clk_5MHz);
                if (key_change === 1'b1) pulses++;
            end
            check_row_outputs(r, pulses);
            case (rows[r].action)
                ACT_RESET:   mid_reset(r);
                ACT_TIMEOUT: silence_timeout(r);
                default: begin
                    for (int i = 7; i <= rows[r].n; i++) begin
                        @(negedge clk_5MHz);
                        if (i == rows[r].n / 2) beep_in = 1'b0;
                    end
                end
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tone_decoder.md
TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 clk_5MHz  input  1  5 MHz system clock; the only clock; all state updates on its rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 beep_in  input  1  square-wave tone from a piano tone generator; asynchronous to clk_5MHz.
REQ-004 key_out  output  4  decoded key, one-hot: 0001 Hdo, 0010 Hre, 0100 Hmi, 1000 Hfa; 0000 means silence or unknown.
REQ-005 key_valid  output  1  high when key_out != 0000.
REQ-006 key_change  output  1  one-cycle pulse whenever key_out changes value.
REQ-007 period_out  output  16  last measured full period of beep_in, in clk_5MHz cycles.

Function
REQ-008 beep_in SHALL pass through a 2-FF synchronizer and then one edge register; rise = sync & ~edge_reg; rise asserts 3 cycles after an input rising edge.
REQ-009 FSM SHALL have three states:
- IDLE: no reference edge.
- ARMED: one rising edge seen.
- TRACK: at least one period measured.
REQ-010 State transitions on rise SHALL be IDLE->ARMED, ARMED->TRACK, TRACK->TRACK.
REQ-011 Counter cnt[15:0] SHALL clear to 0 on rise; otherwise, in ARMED or TRACK, it SHALL increment by 1 and saturate at 65535; in IDLE it SHALL hold 0.
REQ-012 On rise in ARMED or TRACK, the block SHALL compute P = cnt+1, saturating at 65535, and SHALL load period_out <= P.
REQ-013 Classification of P SHALL use windows of nominal ±64 cycles, inclusive:
- Hdo: 19052–19180.
- Hre: 16962–17090.
- Hmi: 15108–15236.
- Hfa: 14256–14384.
- Any P outside every window SHALL classify as 0000.
REQ-014 Nominal periods SHALL be 2*(16384-origin) for origin 6826/7871/8798/9224, giving 19116/17026/15172/14320.
REQ-015 Qualification SHALL use cand[3:0] and hits[1:0]:
- On each classification, if code == cand then hits <= min(hits+1, 2).
- Otherwise cand <= code and hits <= 1.
REQ-016 key_out SHALL load code on the classification edge where the resulting hits == 2 and code != key_out; that means two consecutive matching periods are required, including two for 0000.
REQ-017 key_change SHALL be registered and high for exactly the one cycle following any key_out update; it SHALL never be high in two consecutive cycles.
REQ-018 Silence timeout: when cnt reaches 32767 in ARMED or TRACK without a rise, the FSM SHALL go to IDLE on the next edge. On that same edge:
- key_out <= 0000.
- cand <= 0000.
- hits <= 0.
- key_change pulses if key_out was nonzero.
- period_out holds its value.
REQ-019 If rise and timeout occur on the same cycle, rise SHALL win.
REQ-020 key_valid SHALL be combinational from registered key_out.
REQ-021 period_out SHALL update on every measured period, whether qualified or not.

Reset
REQ-022 When rst is high on a clock edge, the following SHALL clear:
- state <= IDLE.
- cnt, cand, hits <= 0.
- key_out <= 0000.
- period_out <= 0.
- key_change <= 0.
- Both synchronizer FFs and the edge register <= 0.
REQ-023 Reset SHALL take priority over all other events, including mid-measurement and a coincident rise.
REQ-024 After reset, the first beep_in rising edge SHALL only arm the FSM; key_out SHALL not change before the third rise.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Hdo tone, period 19116, from reset -> period_out=19116 after the 2nd rise; key_out=0001, key_valid=1, and one key_change pulse after the 3rd rise.
- Hre (17026) switched to Hfa (14320) -> after 1 Hfa period key_out stays 0010; after the 2nd Hfa period key_out=1000 with one key_change pulse.
- Edge tolerance -> period 15236 decodes 0100; period 15237 twice gives key_out=0000 and key_valid=0.
- Tone 1 Hmi period then held low for 40000 cycles -> timeout after 32767 counted cycles, state IDLE, key_out=0000, key_change pulse; period_out=15172 retained.
- rst asserted mid-Hdo tone with key_out=0001 -> next cycle all outputs 0; tone continuing gives key_out=0001 again only after 3 further rises.
- Jittered periods alternating 19100/19130 -> key_out=0001 stable; key_change pulses exactly once.
